dmem_responder: RTL and testbench

Data-side memory responder for the single-cycle RISC-V core. It receives the core's store/load port (`memwrite`, `aluresult` as address, `writedata`) and returns `readdata` in the same cycle. It serves a word-addressed data RAM plus a small memory-mapped I/O window holding a cycle counter, a timer compare with a sticky interrupt, a status register and an LED register. It sits beside the core in the top-level integration, opposite the core's data interface.

---
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-side responder for the single-cycle core: word RAM plus an optional MMIO window (cycle counter, timer, status, LEDs).
// Latency: loads are combinational (0 cycles); stores commit on the rising clk edge.
// Backpressure: none; one access (load or store) is accepted every cycle.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - asynchronous, active-low reset (registers only; RAM contents are kept)
//   memwrite   - store strobe from the core
//   aluresult  - byte address from the core
//   writedata  - store data
//   readdata   - load data, combinational from aluresult
//   irq        - sticky timer interrupt (STATUS bit 0)
//   leds       - LED register output
//
// Build option DMEM_MMIO_EN: when defined, addresses 0xFFFF_xxxx decode to the MMIO
// registers. When undefined, every address maps to RAM, irq/leds are tied low and
// misaligned stores are dropped without raising a flag.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int LED_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      aluresult,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [LED_W-1:0] leds
);
    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Word RAM shared by both builds. Address bits above AW+1 are ignored,
    // so the array aliases modulo DEPTH words.
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic          aligned;
    logic          store_ok;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    assign word_idx  = aluresult[AW+1:2];
    assign aligned   = (aluresult[1:0] == 2'b00);
    assign store_ok  = memwrite & aligned;
    assign ram_rdata = mem[word_idx];

    // No reset on the array: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= writedata;
        end
    end

`ifdef DMEM_MMIO_EN
    localparam logic [1:0] REG_CYCLE   = 2'd0;
    localparam logic [1:0] REG_TIMECMP = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_LED     = 2'd3;

    logic             is_mmio;
    logic             reg_hit;
    logic [1:0]       reg_sel;
    logic             mmio_we;
    logic             wr_timecmp;
    logic             wr_status;
    logic             wr_led;
    logic             mis_store;
    logic             timer_match;

    logic [31:0]      cycle_q;
    logic [31:0]      timecmp_q;
    logic             pend_q;
    logic             mis_q;
    logic [LED_W-1:0] led_q;
    logic             pend_d;
    logic             mis_d;

    logic [31:0]      led_rd;
    logic [31:0]      mmio_rdata;

    assign is_mmio = (aluresult[31:16] == 16'hFFFF);
    // Only offsets 0x0..0xF hold registers; reg_sel comes from bits 3:2 so a
    // misaligned read still returns the register containing that byte.
    assign reg_hit = (aluresult[15:4] == 12'h000);
    assign reg_sel = aluresult[3:2];

    assign ram_we     = store_ok & ~is_mmio;
    assign mmio_we    = store_ok & is_mmio & reg_hit;
    assign wr_timecmp = mmio_we & (reg_sel == REG_TIMECMP);
    assign wr_status  = mmio_we & (reg_sel == REG_STATUS);
    assign wr_led     = mmio_we & (reg_sel == REG_LED);

    // Misaligned store anywhere (RAM or MMIO) raises the sticky flag.
    assign mis_store   = memwrite & ~aligned;
    // Compare uses the registered TIMECMP, so a write in this cycle only
    // affects the compare from the next edge onward.
    assign timer_match = (cycle_q == timecmp_q);

    // Set has priority over a simultaneous write-1-to-clear.
    always_comb begin
        pend_d = timer_match | (pend_q & ~(wr_status & writedata[0]));
        mis_d  = mis_store   | (mis_q  & ~(wr_status & writedata[1]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= 32'd0;
            timecmp_q <= 32'hFFFF_FFFF;
            pend_q    <= 1'b0;
            mis_q     <= 1'b0;
            led_q     <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
            if (wr_timecmp) begin
                timecmp_q <= writedata;
            end
            if (wr_led) begin
                led_q <= writedata[LED_W-1:0];
            end
        end
    end

    always_comb begin
        led_rd             = '0;
        led_rd[LED_W-1:0]  = led_q;
        mmio_rdata         = '0;
        if (reg_hit) begin
            case (reg_sel)
                REG_CYCLE:   mmio_rdata = cycle_q;
                REG_TIMECMP: mmio_rdata = timecmp_q;
                REG_STATUS:  mmio_rdata = {30'd0, mis_q, pend_q};
                REG_LED:     mmio_rdata = led_rd;
            endcase
        end
        readdata = is_mmio ? mmio_rdata : ram_rdata;
    end

    assign irq  = pend_q;
    assign leds = led_q;
`else
    assign ram_we   = store_ok;
    assign readdata = ram_rdata;
    assign irq      = 1'b0;
    assign leds     = '0;

    // Without the MMIO window there is no register state, so reset and the
    // upper address bits have no function in this build.
    logic unused_inputs;
    assign unused_inputs = reset ^ (^aluresult[31:AW+2]);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int LED_W = 8;
    localparam int AW    = $clog2(DEPTH);
`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             memwrite;
    logic [31:0]      aluresult;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             irq;
    logic [LED_W-1:0] leds;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] mcyc;
    logic [31:0] e;
    string       n;

    dmem_responder #(.DEPTH(DEPTH), .LED_W(LED_W)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .memwrite  (memwrite),
        .aluresult (aluresult),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .leds      (leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcyc <= 32'd0;
        else        mcyc <= mcyc + 32'd1;
    end

    function automatic logic is_mmio_addr(input logic [31:0] a);
        return MMIO && (a[31:16] == 16'hFFFF);
    endfunction

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite  = we;
        aluresult = a;
        writedata = d;
    endtask

    task automatic expect_rd(input logic [31:0] d, input string nm);
        exp_q.push_back(d);
        name_q.push_back(nm);
    endtask

    task automatic ram_access(input logic we, input logic [31:0] a, input logic [31:0] d, input string nm);
        logic [AW-1:0] idx;
        idx = a[AW+1:2];
        drive(we, a, d);
        expect_rd(model[idx], nm);
        if (we && a[1:0] == 2'b00 && !is_mmio_addr(a)) model[idx] = d;
    endtask

    task automatic mmio_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] ex, input string nm);
        drive(we, a, d);
        expect_rd(ex, nm);
    endtask

    task automatic wait_cycle(input logic [31:0] target, input logic [31:0] a);
        int guard;
        guard = 0;
        while (mcyc != target && guard < 200) begin
            drive(1'b0, a, 32'd0);
            guard++;
        end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL wait_cycle: reached=%0d required=%0d", mcyc, target);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got=%b want=0", irq); end
        checks++; if (leds !== '0) begin errors++; $display("FAIL reset_leds: got=%h want=0", leds); end
`ifdef DMEM_MMIO_EN
        mmio_access(1'b0, 32'hFFFF_0004, 32'd0, 32'hFFFF_FFFF, "reset_timecmp");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        @(negedge clk);
        aluresult = 32'hFFFF_0000;
        rst_n     = 1'b1;
        expect_rd(32'd0, "cycle_first_after_release");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_0000, 32'd0, 32'd1, "cycle_second_after_release");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
`else
        @(negedge clk);
        rst_n = 1'b1;
`endif
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'(i * 4), 32'hA500_0000 ^ (32'(i) * 32'h0101_0101));
            model[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < DEPTH; i += 3) begin
            ram_access(1'b0, 32'(i * 4), 32'd0, $sformatf("preload_rd[%0d]", i));
            #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        end
    endtask

    task automatic test_store_load();
        // store with same-cycle read (old value), reload, reload via alias
        for (int i = 0; i < 3; i++) begin
            ram_access(i == 0, (i == 2) ? 32'h10 + 32'(4 * DEPTH) : 32'h10, 32'hDEAD_BEEF,
                       $sformatf("store_load[%0d]", i));
            #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        end
        checks++;
        if (model[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL model_word4: got=%h want=deadbeef", model[4]); end
    endtask

    task automatic test_misaligned();
        ram_access(1'b1, 32'h6, 32'h1234_5678, "mis_store_old");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        ram_access(1'b0, 32'h4, 32'd0, "mis_store_suppressed");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        ram_access(1'b0, 32'h7, 32'd0, "mis_read");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
`ifdef DMEM_MMIO_EN
        mmio_access(1'b0, 32'hFFFF_0008, 32'd0, 32'd2, "status_misalign");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b1, 32'hFFFF_0008, 32'd2, 32'd2, "status_w1c_old");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_0008, 32'd0, 32'd0, "status_misalign_cleared");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
`endif
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_timer();
        @(negedge clk);
        memwrite = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        mmio_access(1'b1, 32'hFFFF_0004, 32'd20, 32'hFFFF_FFFF, "timecmp_wr_old");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        wait_cycle(32'd20, 32'hFFFF_0000);
        expect_rd(32'd20, "cycle_at_match");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_in_match_cycle: got=%b want=0", irq); end
        mmio_access(1'b0, 32'hFFFF_0008, 32'd0, 32'd1, "status_pending");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_match: got=%b want=1", irq); end
        repeat (3) drive(1'b0, 32'hFFFF_0008, 32'd0);
        #2; checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got=%b want=1", irq); end
        mmio_access(1'b1, 32'hFFFF_0008, 32'd1, 32'd1, "status_w1c_pending_old");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_0008, 32'd0, 32'd0, "status_after_w1c");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got=%b want=0", irq); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] t1, t2;
        t1 = mcyc + 32'd3;
        mmio_access(1'b1, 32'hFFFF_0004, t1, 32'd20, "timecmp_prev_value");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        wait_cycle(t1 + 32'd1, 32'hFFFF_0008);
        #2; checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_second_match: got=%b want=1", irq); end
        t2 = mcyc + 32'd4;
        mmio_access(1'b1, 32'hFFFF_0004, t2, t1, "timecmp_wr2_old");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        wait_cycle(t2 - 32'd1, 32'hFFFF_0008);
        // this store lands in the cycle where CYCLE == TIMECMP
        mmio_access(1'b1, 32'hFFFF_0008, 32'd1, 32'd1, "status_at_race");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_0008, 32'd0, 32'd1, "set_wins_over_clear");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_race: got=%b want=1", irq); end
    endtask

    task automatic test_led_cycle();
        mmio_access(1'b1, 32'hFFFF_000C, 32'h1FF, 32'd0, "led_wr_old");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_000C, 32'd0, 32'hFF, "led_rd");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (leds !== 8'hFF) begin errors++; $display("FAIL leds_out: got=%h want=ff", leds); end
        mmio_access(1'b1, 32'hFFFF_000D, 32'd0, 32'hFF, "led_mis_store");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_000E, 32'd0, 32'hFF, "led_mis_rd");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        drive(1'b1, 32'hFFFF_0000, 32'h1234);
        expect_rd(mcyc, "cycle_wr_ignored");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        drive(1'b0, 32'hFFFF_0000, 32'd0);
        expect_rd(mcyc, "cycle_keeps_counting");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b1, 32'hFFFF_0010, 32'hDEAD_BEEF, 32'd0, "unmapped_wr");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_0010, 32'd0, 32'd0, "unmapped_rd");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        ram_access(1'b0, 32'hC, 32'd0, "ram_idx3_untouched");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] ra [4];
        logic [31:0] rv [4];
        ra = '{32'hFFFF_000C, 32'hFFFF_0008, 32'hFFFF_0004, 32'hFFFF_0000};
        rv = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        mmio_access(1'b1, 32'hFFFF_000C, 32'h5A, 32'hFF, "led_wr_5a");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_0008, 32'd0, 32'd3, "status_before_reset");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (leds !== 8'h5A) begin errors++; $display("FAIL leds_5a: got=%h want=5a", leds); end
        @(negedge clk);
        memwrite = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aluresult = ra[i];
            expect_rd(rv[i], $sformatf("midrun_reset_reg[%0d]", i));
            #1; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        end
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL midrun_leds: got=%h want=0", leds); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrun_irq: got=%b want=0", irq); end
        @(negedge clk);
        aluresult = 32'hFFFF_0000;
        rst_n     = 1'b1;
        expect_rd(32'd0, "midrun_cycle_first");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        mmio_access(1'b0, 32'hFFFF_0000, 32'd0, 32'd1, "midrun_cycle_second");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        ram_access(1'b0, 32'h10, 32'd0, "ram_kept_over_reset");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
    endtask
`else
    task automatic test_ffff_alias();
        ram_access(1'b1, 32'hFFFF_000C, 32'hCAFE_F00D, "ffff_store_old");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        ram_access(1'b0, 32'h0000_000C, 32'd0, "ffff_lands_idx3");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++;
        if (model[3] !== 32'hCAFE_F00D) begin errors++; $display("FAIL model_idx3: got=%h want=cafef00d", model[3]); end
        ram_access(1'b0, 32'hFFFF_0000, 32'd0, "ffff_read_idx0");
        #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got=%b want=0", irq); end
        checks++; if (leds !== '0) begin errors++; $display("FAIL leds_tied: got=%h want=0", leds); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        memwrite = 1'b0;
        rst_n    = 1'b0;
        aluresult = 32'h10;
        expect_rd(model[4], "ram_kept_in_reset");
        #1; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (readdata !== e) begin errors++; $display("FAIL %s: got=%h want=%h", n, readdata, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrun_irq: got=%b want=0", irq); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            a = {1'b0, $urandom_range(7, 0) == 0 ? 3'd0 : 3'($urandom), 28'($urandom)};
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            ram_access(1'($urandom), a, $urandom, $sformatf("b2b[%0d]", i));
            #2; e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (readdata !== e) begin errors++; $display("FAIL %s: addr=%h got=%h want=%h", n, a, readdata, e); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        memwrite  = 1'b0;
        aluresult = 32'd0;
        writedata = 32'd0;
        test_reset();
        preload();
        test_store_load();
        test_misaligned();
`ifdef DMEM_MMIO_EN
        test_timer();
        test_w1c_race();
        test_led_cycle();
        test_reset_midrun();
`else
        test_ffff_alias();
        test_reset_midrun();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
